// File: rtl/posit_encode.sv
// posit_encode: 3-stage pipelined posit packer (decoded sign/regime/exponent/mantissa/specials in, N-bit posit out, valid/ready on both sides)
module posit_encode #(
  parameter int N  = 8,
  parameter int ES = 4,
  parameter int RS = $clog2(N)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          InValid,
  output logic          InReady,
  input  logic          Sign,
  input  logic [RS:0]   RegimeValue,
  input  logic [ES-1:0] Exponent,
  input  logic [N-1:0]  Mantissa,
  input  logic          inf,
  input  logic          zero,
  output logic [N-1:0]  Out,
  output logic          OutValid,
  input  logic          OutReady
);
  localparam int W  = 2*N+ES;
  localparam int RW = RS+1;
  localparam logic signed [RS:0] K_HI = RW'(N-2);
  localparam logic signed [RS:0] K_LO = RW'(1-N);
  logic              w_stall;
  logic signed [RS:0] w_k;
  logic [RS:0]       w_mag;
  logic              r1_v, r1_sign, r1_inf, r1_zero, r1_max, r1_min;
  logic [N-1:0]      r1_reg;
  logic [RS:0]       r1_rlen;
  logic [ES-1:0]     r1_exp;
  logic [N-1:0]      r1_frac;
  logic [W-1:0]      w_tail, w_buf;
  logic [N-2:0]      w_body, w_res;
  logic              w_guard, w_sticky, w_up;
  logic [N-1:0]      w_sum;
  logic              r2_v, r2_sign, r2_inf, r2_zero;
  logic [N-2:0]      r2_body;
  logic [N-1:0]      w_pos, w_out;
  assign w_stall = OutValid & ~OutReady;
  assign InReady = ~w_stall;
  assign w_k     = RegimeValue;
  assign w_mag   = w_k[RS] ? -RegimeValue : RegimeValue;
  // hidden bit is dropped by the shift, leaving the fraction left-aligned with a zero LSB
  assign w_tail   = {r1_exp, r1_frac, {N{1'b0}}};
  assign w_buf    = {r1_reg, {(W-N){1'b0}}} | (w_tail >> r1_rlen);
  assign w_body   = w_buf[W-1 -: N-1];
  assign w_guard  = w_buf[W-N];
  assign w_sticky = |w_buf[W-N-1:0];
  assign w_up     = w_guard & (w_sticky | w_body[0]);
  assign w_sum    = {1'b0, w_body} + {{(N-1){1'b0}}, w_up};
  // rounding carry into the sign position saturates to maxpos; a zero body becomes minpos
  assign w_res    = (r1_max | w_sum[N-1]) ? {(N-1){1'b1}} :
                    (r1_min | ~|w_sum)    ? {{(N-2){1'b0}}, 1'b1} : w_sum[N-2:0];
  assign w_pos    = {1'b0, r2_body};
  assign w_out    = r2_inf ? {1'b1, {(N-1){1'b0}}} : r2_zero ? '0 : r2_sign ? -w_pos : w_pos;
  always_ff @(posedge Clk or posedge Reset)
    if (Reset) begin
      r1_v     <= 1'b0;
      r1_sign  <= 1'b0;
      r1_inf   <= 1'b0;
      r1_zero  <= 1'b0;
      r1_max   <= 1'b0;
      r1_min   <= 1'b0;
      r1_reg   <= '0;
      r1_rlen  <= '0;
      r1_exp   <= '0;
      r1_frac  <= '0;
      r2_v     <= 1'b0;
      r2_sign  <= 1'b0;
      r2_inf   <= 1'b0;
      r2_zero  <= 1'b0;
      r2_body  <= '0;
      OutValid <= 1'b0;
      Out      <= '0;
    end else if (!w_stall) begin
      r1_v     <= InValid;
      r1_sign  <= Sign;
      r1_inf   <= inf;
      r1_zero  <= zero & ~inf;
      r1_max   <= w_k >= K_HI;
      r1_min   <= w_k <= K_LO;
      r1_rlen  <= w_k[RS] ? w_mag + RW'(1) : w_mag + RW'(2);
      r1_reg   <= w_k[RS] ? ({1'b1, {(N-1){1'b0}}} >> w_mag) : ~({N{1'b1}} >> (w_mag + RW'(1)));
      r1_exp   <= Exponent;
      r1_frac  <= Mantissa << 1;
      r2_v     <= r1_v;
      r2_sign  <= r1_sign;
      r2_inf   <= r1_inf;
      r2_zero  <= r1_zero;
      r2_body  <= w_res;
      OutValid <= r2_v;
      Out      <= w_out;
    end
endmodule
